// File: rtl/inst_seq_pkg.sv
// Shared types and default widths for the instruction loop sequencer.
package inst_seq_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } seq_state_e;

   localparam int unsigned DefInstWidth    = 32;
   localparam int unsigned DefNumInsts     = 64;
   localparam int unsigned DefLoopCntWidth = 16;

endpackage

// File: rtl/inst_mem_regfile.sv
// Program store: synchronous write, combinational read, no reset on contents.
module inst_mem_regfile #(
   parameter int unsigned InstWidth = 32,
   parameter int unsigned NumInsts  = 64,
   parameter int unsigned AddrWidth = $clog2(NumInsts)
) (
   input  logic                 clk_i,
   input  logic                 wr_en_i,
   input  logic [AddrWidth-1:0] wr_addr_i,
   input  logic [InstWidth-1:0] wr_data_i,
   input  logic [AddrWidth-1:0] rd_addr_i,
   output logic [InstWidth-1:0] rd_data_o
);

   logic [InstWidth-1:0] mem_q [NumInsts];

   always_ff @(posedge clk_i) begin
      if (wr_en_i) begin
         mem_q[wr_addr_i] <= wr_data_i;
      end
   end

   assign rd_data_o = mem_q[rd_addr_i];

endmodule

// File: rtl/inst_loop_sequencer.sv
// Fetches instructions from a local program store and streams them to the
// decoder, with one hardware loop region of programmable iteration count.
module inst_loop_sequencer
   import inst_seq_pkg::*;
#(
   parameter int unsigned InstWidth    = DefInstWidth,
   parameter int unsigned NumInsts     = DefNumInsts,
   parameter int unsigned AddrWidth    = $clog2(NumInsts),
   parameter int unsigned LoopCntWidth = DefLoopCntWidth
) (
   input  logic                    clk_i,
   input  logic                    rst_ni,
   input  logic                    start_i,
   input  logic                    clr_i,
   input  logic                    inst_wr_en_i,
   input  logic [AddrWidth-1:0]    inst_wr_addr_i,
   input  logic [InstWidth-1:0]    inst_wr_data_i,
   input  logic [AddrWidth-1:0]    cfg_last_addr_i,
   input  logic                    cfg_loop_en_i,
   input  logic [AddrWidth-1:0]    cfg_loop_start_i,
   input  logic [AddrWidth-1:0]    cfg_loop_end_i,
   input  logic [LoopCntWidth-1:0] cfg_loop_count_i,
   output logic [InstWidth-1:0]    inst_o,
   output logic                    inst_valid_o,
   input  logic                    inst_ready_i,
   output logic [AddrWidth-1:0]    pc_o,
   output logic [LoopCntWidth-1:0] loop_iter_o,
   output logic                    busy_o,
   output logic                    done_o
);

   seq_state_e              state_q, state_d;
   logic [AddrWidth-1:0]    pc_q, pc_d;
   logic [LoopCntWidth-1:0] iter_q, iter_d;
   logic                    done_q, done_d;
   logic                    cfg_load;

   logic [AddrWidth-1:0]    last_addr_q, loop_start_q, loop_end_q;
   logic                    loop_en_q;
   logic [LoopCntWidth-1:0] loop_count_q;

   logic                    mem_wr_en;
   logic                    handshake;
   logic [LoopCntWidth:0]   iter_inc;
   logic [LoopCntWidth:0]   count_eff;
   logic                    loop_back;

   assign mem_wr_en = inst_wr_en_i & (state_q == IDLE);

   inst_mem_regfile #(
      .InstWidth (InstWidth),
      .NumInsts  (NumInsts),
      .AddrWidth (AddrWidth)
   ) u_mem (
      .clk_i     (clk_i),
      .wr_en_i   (mem_wr_en),
      .wr_addr_i (inst_wr_addr_i),
      .wr_data_i (inst_wr_data_i),
      .rd_addr_i (pc_q),
      .rd_data_o (inst_o)
   );

   // Counts of 0 and 1 both mean a single body pass; compare one bit wider to avoid overflow.
   assign iter_inc  = {1'b0, iter_q} + {{LoopCntWidth{1'b0}}, 1'b1};
   assign count_eff = (loop_count_q == '0) ? {{LoopCntWidth{1'b0}}, 1'b1}
                                           : {1'b0, loop_count_q};
   assign loop_back = loop_en_q & (pc_q == loop_end_q) & (iter_inc < count_eff);
   assign handshake = (state_q == RUN) & inst_ready_i;

   always_comb begin
      state_d  = state_q;
      pc_d     = pc_q;
      iter_d   = iter_q;
      done_d   = 1'b0;
      cfg_load = 1'b0;
      if (clr_i) begin
         state_d = IDLE;
         pc_d    = '0;
         iter_d  = '0;
      end else if (state_q == IDLE) begin
         if (start_i) begin
            state_d  = RUN;
            pc_d     = '0;
            iter_d   = '0;
            cfg_load = 1'b1;
         end
      end else if (handshake) begin
         // Loop-back wins over completion when the loop ends on the last address.
         if (loop_back) begin
            pc_d   = loop_start_q;
            iter_d = iter_inc[LoopCntWidth-1:0];
         end else if (pc_q == last_addr_q) begin
            state_d = IDLE;
            pc_d    = '0;
            iter_d  = '0;
            done_d  = 1'b1;
         end else begin
            pc_d = pc_q + AddrWidth'(1);
            if (pc_q == loop_end_q) begin
               iter_d = '0;
            end
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= IDLE;
         pc_q    <= '0;
         iter_q  <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         iter_q  <= iter_d;
         done_q  <= done_d;
      end
   end

   // Configuration is captured at start so changes during a run are invisible.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         last_addr_q  <= '0;
         loop_en_q    <= 1'b0;
         loop_start_q <= '0;
         loop_end_q   <= '0;
         loop_count_q <= '0;
      end else if (cfg_load) begin
         last_addr_q  <= cfg_last_addr_i;
         loop_en_q    <= cfg_loop_en_i;
         loop_start_q <= cfg_loop_start_i;
         loop_end_q   <= cfg_loop_end_i;
         loop_count_q <= cfg_loop_count_i;
      end
   end

   assign inst_valid_o = (state_q == RUN);
   assign busy_o       = (state_q == RUN);
   assign pc_o         = pc_q;
   assign loop_iter_o  = iter_q;
   assign done_o       = done_q;

endmodule

// File: tb/tb_inst_loop_sequencer.sv
// Scoreboard bench for inst_loop_sequencer: expected fetch order is expanded
// from the program shape and compared at every decoder handshake.
module tb_inst_loop_sequencer;

   logic        clk_i = 1'b0;
   logic        rst_ni = 1'b0;
   logic        start_i = 1'b0;
   logic        clr_i = 1'b0;
   logic        inst_wr_en_i = 1'b0;
   logic [5:0]  inst_wr_addr_i = '0;
   logic [31:0] inst_wr_data_i = '0;
   logic [5:0]  cfg_last_addr_i = '0;
   logic        cfg_loop_en_i = 1'b0;
   logic [5:0]  cfg_loop_start_i = '0;
   logic [5:0]  cfg_loop_end_i = '0;
   logic [15:0] cfg_loop_count_i = '0;
   logic [31:0] inst_o;
   logic        inst_valid_o;
   logic        inst_ready_i = 1'b0;
   logic [5:0]  pc_o;
   logic [15:0] loop_iter_o;
   logic        busy_o;
   logic        done_o;

   typedef struct {
      logic [5:0]  pc;
      logic [31:0] inst;
      logic [15:0] iter;
   } exp_t;

   exp_t        sb[$];
   logic [31:0] tb_mem [64];
   int          vecs = 0;
   int          errs = 0;

   always #5 clk_i = ~clk_i;

   inst_loop_sequencer dut (
      .clk_i            (clk_i),
      .rst_ni           (rst_ni),
      .start_i          (start_i),
      .clr_i            (clr_i),
      .inst_wr_en_i     (inst_wr_en_i),
      .inst_wr_addr_i   (inst_wr_addr_i),
      .inst_wr_data_i   (inst_wr_data_i),
      .cfg_last_addr_i  (cfg_last_addr_i),
      .cfg_loop_en_i    (cfg_loop_en_i),
      .cfg_loop_start_i (cfg_loop_start_i),
      .cfg_loop_end_i   (cfg_loop_end_i),
      .cfg_loop_count_i (cfg_loop_count_i),
      .inst_o           (inst_o),
      .inst_valid_o     (inst_valid_o),
      .inst_ready_i     (inst_ready_i),
      .pc_o             (pc_o),
      .loop_iter_o      (loop_iter_o),
      .busy_o           (busy_o),
      .done_o           (done_o)
   );

   task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
      vecs++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
      end
   endtask

   task automatic mem_write(input int addr, input logic [31:0] data);
      @(negedge clk_i);
      inst_wr_en_i   = 1'b1;
      inst_wr_addr_i = 6'(addr);
      inst_wr_data_i = data;
      @(negedge clk_i);
      inst_wr_en_i   = 1'b0;
      tb_mem[addr]   = data;
   endtask

   task automatic push_exp(input int a, input int it);
      exp_t e;
      e.pc   = 6'(a);
      e.inst = tb_mem[a];
      e.iter = 16'(it);
      sb.push_back(e);
   endtask

   // Expected fetch order: prefix, body repeated max(cnt,1) times, suffix.
   task automatic build_exp(input int last, input bit en, input int ls, input int le, input int cnt);
      int n;
      sb.delete();
      if (!en) begin
         for (int a = 0; a <= last; a++) push_exp(a, 0);
      end else begin
         n = (cnt == 0) ? 1 : cnt;
         for (int a = 0; a < ls; a++) push_exp(a, 0);
         for (int k = 0; k < n; k++)
            for (int a = ls; a <= le; a++) push_exp(a, k);
         for (int a = le + 1; a <= last; a++) push_exp(a, 0);
      end
   endtask

   task automatic run_prog(input int last, input bit en, input int ls, input int le, input int cnt,
                           input bit rnd, input bit wr0, input logic [31:0] wr0_data);
      bit          stall;
      bit          finished;
      logic [5:0]  ppc;
      logic [31:0] pinst;
      exp_t        e;
      if (wr0) tb_mem[0] = wr0_data;
      build_exp(last, en, ls, le, cnt);
      @(negedge clk_i);
      cfg_last_addr_i  = 6'(last);
      cfg_loop_en_i    = en;
      cfg_loop_start_i = 6'(ls);
      cfg_loop_end_i   = 6'(le);
      cfg_loop_count_i = 16'(cnt);
      start_i          = 1'b1;
      inst_ready_i     = 1'b1;
      if (wr0) begin
         inst_wr_en_i   = 1'b1;
         inst_wr_addr_i = '0;
         inst_wr_data_i = wr0_data;
      end
      @(negedge clk_i);
      start_i      = 1'b0;
      inst_wr_en_i = 1'b0;
      cfg_last_addr_i  = 6'd1;
      cfg_loop_en_i    = ~en;
      cfg_loop_start_i = 6'd0;
      cfg_loop_end_i   = 6'd0;
      cfg_loop_count_i = 16'd9;
      stall    = 1'b0;
      finished = 1'b0;
      ppc      = '0;
      pinst    = '0;
      for (int cyc = 0; cyc < 400; cyc++) begin
         check_val("busy_run", 32'(busy_o), 32'd1);
         if (stall) begin
            check_val("pc_stable", 32'(pc_o), 32'(ppc));
            check_val("inst_stable", inst_o, pinst);
         end
         if (inst_valid_o && inst_ready_i) begin
            if (sb.size() == 0) begin
               check_val("extra_fetch", 32'(pc_o), 32'hFFFF_FFFF);
            end else begin
               e = sb.pop_front();
               check_val("pc", 32'(pc_o), 32'(e.pc));
               check_val("inst", inst_o, e.inst);
               check_val("iter", 32'(loop_iter_o), 32'(e.iter));
            end
            stall = 1'b0;
            if (sb.size() == 0) begin
               finished = 1'b1;
               break;
            end
         end else begin
            stall = inst_valid_o;
            ppc   = pc_o;
            pinst = inst_o;
         end
         @(posedge clk_i);
         #1;
         inst_ready_i = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
         @(negedge clk_i);
      end
      check_val("run_complete", 32'(finished), 32'd1);
      @(negedge clk_i);
      check_val("done_pulse", 32'(done_o), 32'd1);
      check_val("valid_after", 32'(inst_valid_o), 32'd0);
      check_val("busy_after", 32'(busy_o), 32'd0);
      check_val("pc_after", 32'(pc_o), 32'd0);
      check_val("iter_after", 32'(loop_iter_o), 32'd0);
      @(negedge clk_i);
      check_val("done_single", 32'(done_o), 32'd0);
   endtask

   initial begin
      #12;
      check_val("rst_valid", 32'(inst_valid_o), 32'd0);
      check_val("rst_busy", 32'(busy_o), 32'd0);
      check_val("rst_done", 32'(done_o), 32'd0);
      check_val("rst_pc", 32'(pc_o), 32'd0);
      check_val("rst_iter", 32'(loop_iter_o), 32'd0);
      @(negedge clk_i);
      rst_ni = 1'b1;

      for (int i = 0; i < 16; i++) mem_write(i, 32'hA000_0000 + 32'(i * 17));

      // Straight-line, loop, and loop under random backpressure.
      run_prog(3, 1'b0, 0, 0, 0, 1'b0, 1'b0, '0);
      run_prog(3, 1'b1, 1, 2, 3, 1'b0, 1'b0, '0);
      run_prog(3, 1'b1, 1, 2, 3, 1'b1, 1'b0, '0);
      // Edge loop configurations.
      run_prog(3, 1'b1, 1, 2, 0, 1'b0, 1'b0, '0);
      run_prog(3, 1'b1, 2, 3, 2, 1'b0, 1'b0, '0);
      run_prog(5, 1'b1, 0, 5, 3, 1'b1, 1'b0, '0);
      // Write to address 0 coincident with start is visible to the first fetch.
      run_prog(3, 1'b0, 0, 0, 0, 1'b0, 1'b1, 32'h1234_5678);

      // Abort at pc 2 during a looping run.
      @(negedge clk_i);
      cfg_last_addr_i = 6'd3; cfg_loop_en_i = 1'b1; cfg_loop_start_i = 6'd1;
      cfg_loop_end_i = 6'd2; cfg_loop_count_i = 16'd3;
      start_i = 1'b1; inst_ready_i = 1'b1;
      @(negedge clk_i);
      start_i = 1'b0;
      for (int c = 0; c < 20 && pc_o != 6'd2; c++) @(negedge clk_i);
      check_val("abort_reach_pc2", 32'(pc_o), 32'd2);
      clr_i = 1'b1;
      @(negedge clk_i);
      clr_i = 1'b0;
      check_val("abort_valid", 32'(inst_valid_o), 32'd0);
      check_val("abort_pc", 32'(pc_o), 32'd0);
      check_val("abort_iter", 32'(loop_iter_o), 32'd0);
      check_val("abort_done", 32'(done_o), 32'd0);
      @(negedge clk_i);
      check_val("abort_done_late", 32'(done_o), 32'd0);

      // clr coincident with start wins.
      start_i = 1'b1; clr_i = 1'b1;
      @(negedge clk_i);
      start_i = 1'b0; clr_i = 1'b0;
      check_val("clr_start_busy", 32'(busy_o), 32'd0);

      // Writes and start pulses during RUN are ignored.
      cfg_last_addr_i = 6'd3; cfg_loop_en_i = 1'b0;
      start_i = 1'b1; inst_ready_i = 1'b0;
      @(negedge clk_i);
      start_i = 1'b0;
      inst_wr_en_i = 1'b1; inst_wr_addr_i = '0; inst_wr_data_i = 32'hDEAD_BEEF;
      @(negedge clk_i);
      inst_wr_en_i = 1'b0;
      check_val("guard_pc0", 32'(pc_o), 32'd0);
      check_val("guard_inst0", inst_o, tb_mem[0]);
      inst_ready_i = 1'b1;
      @(negedge clk_i);
      check_val("guard_pc1", 32'(pc_o), 32'd1);
      start_i = 1'b1;
      @(negedge clk_i);
      start_i = 1'b0;
      check_val("guard_no_restart", 32'(pc_o), 32'd2);
      clr_i = 1'b1;
      @(negedge clk_i);
      clr_i = 1'b0;
      run_prog(3, 1'b0, 0, 0, 0, 1'b0, 1'b0, '0);

      // Asynchronous reset in the middle of a run.
      @(negedge clk_i);
      cfg_last_addr_i = 6'd3; cfg_loop_en_i = 1'b1; cfg_loop_start_i = 6'd1;
      cfg_loop_end_i = 6'd2; cfg_loop_count_i = 16'd3;
      start_i = 1'b1; inst_ready_i = 1'b1;
      @(negedge clk_i);
      start_i = 1'b0;
      repeat (3) @(negedge clk_i);
      check_val("pre_rst_busy", 32'(busy_o), 32'd1);
      #2 rst_ni = 1'b0;
      #1;
      check_val("arst_valid", 32'(inst_valid_o), 32'd0);
      check_val("arst_busy", 32'(busy_o), 32'd0);
      check_val("arst_pc", 32'(pc_o), 32'd0);
      check_val("arst_iter", 32'(loop_iter_o), 32'd0);
      check_val("arst_done", 32'(done_o), 32'd0);
      @(negedge clk_i);
      rst_ni = 1'b1;
      run_prog(3, 1'b1, 1, 2, 2, 1'b1, 1'b0, '0);

      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1, "simulation time limit");
   end

endmodule
